// File: rtl/soc_system_pio_start_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_pio_start_ctrl
// Description : Multi-channel accelerator start/done controller on an Avalon-MM
//               slave. Start lines run in level or auto-clearing pulse mode,
//               with atomic set/clear writes. Rising done edges are captured in
//               a W1C register. Per-channel busy tracking and a maskable level
//               interrupt are also provided.
//               Optional build macro PIO_START_DONE_SYNC_EN inserts a 2-flop
//               synchroniser on in_done for accelerators on foreign clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_system_pio_start_ctrl #(
    parameter int          WIDTH       = 4,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          PULSE_LEN   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    input  logic [WIDTH-1:0] in_done,
    output logic             irq
);

    localparam int CNT_W = (PULSE_LEN < 2) ? 1 : $clog2(PULSE_LEN + 1);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MODE   = 3'd1;
    localparam logic [2:0] ADDR_EDGE   = 3'd2;
    localparam logic [2:0] ADDR_IRQMSK = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
    localparam logic [2:0] ADDR_BUSY   = 3'd6;

    logic [WIDTH-1:0] data_q,  data_d;
    logic [WIDTH-1:0] mode_q,  mode_d;
    logic [WIDTH-1:0] edge_q,  edge_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [WIDTH-1:0] busy_q,  busy_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] prev_q;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] done_s;
    logic [WIDTH-1:0] rise;
    logic             unused_wd;

    assign wr        = chipselect && !write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = &{1'b0, writedata};

`ifdef PIO_START_DONE_SYNC_EN
    logic [WIDTH-1:0] sync1_q, sync2_q;

    // Two-flop synchroniser for done lines from asynchronous clock domains
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_done;
            sync2_q <= sync1_q;
        end
    end
    assign done_s = sync2_q;
`else
    logic [WIDTH-1:0] samp_q;

    // Single sampling flop; in_done is already synchronous to clk here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_q <= '0;
        end else begin
            samp_q <= in_done;
        end
    end
    assign done_s = samp_q;
`endif

    assign rise = done_s & ~prev_q;

    // Next-state for start bits, pulse counters, edge capture and busy status
    always_comb begin
        mode_d = (wr && address == ADDR_MODE)   ? wd : mode_q;
        mask_d = (wr && address == ADDR_IRQMSK) ? wd : mask_q;
        w1c    = (wr && address == ADDR_EDGE)   ? wd : '0;

        req = data_q;
        if (wr) begin
            case (address)
                ADDR_DATA:   req = wd;
                ADDR_OUTSET: req = data_q | wd;
                ADDR_OUTCLR: req = data_q & ~wd;
                default:     req = data_q;
            endcase
        end

        data_d = req;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            // A channel whose MODE bit is cleared this cycle behaves as level
            // mode, so it freezes at its current level with the counter zeroed.
            if (mode_q[i] && mode_d[i]) begin
                if (req[i] && !data_q[i]) begin
                    data_d[i] = 1'b1;
                    cnt_d[i]  = CNT_W'(PULSE_LEN);
                end else if (!req[i]) begin
                    data_d[i] = 1'b0;
                    cnt_d[i]  = '0;
                end else if (cnt_q[i] == CNT_W'(1)) begin
                    data_d[i] = 1'b0;
                    cnt_d[i]  = '0;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i]  = cnt_q[i] - CNT_W'(1);
                end
            end else begin
                data_d[i] = req[i];
                cnt_d[i]  = '0;
            end
        end

        // Hardware set beats a simultaneous software clear
        edge_d = (edge_q & ~w1c) | rise;
        // A new start beats a simultaneous done edge
        busy_d = (busy_q & ~rise) | (data_d & ~data_q);
    end

    // Register state; reset aborts any pulse in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE[WIDTH-1:0];
            mode_q <= '0;
            edge_q <= '0;
            mask_q <= '0;
            busy_q <= '0;
            prev_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            data_q <= data_d;
            mode_q <= mode_d;
            edge_q <= edge_d;
            mask_q <= mask_d;
            busy_q <= busy_d;
            prev_q <= done_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Zero-wait-state read mux; unused and write-only addresses read 0
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0] = data_q;
            ADDR_MODE:   readdata[WIDTH-1:0] = mode_q;
            ADDR_EDGE:   readdata[WIDTH-1:0] = edge_q;
            ADDR_IRQMSK: readdata[WIDTH-1:0] = mask_q;
            ADDR_BUSY:   readdata[WIDTH-1:0] = busy_q;
            default:     readdata = '0;
        endcase
    end

    assign out_port = data_q;
    assign irq      = |(edge_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pio_start_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_system_pio_start_ctrl
// Description : Self-checking bench for soc_system_pio_start_ctrl. A vector
//               table plus hand-written sequences; expected results go into a
//               scoreboard queue at drive time and are compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_system_pio_start_ctrl;

`ifdef PIO_START_DONE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rst8_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata, rd8;
    logic [3:0]  out_port, out8;
    logic [3:0]  in_done;
    logic        irq, irq8;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        bit          w;
        logic [2:0]  a;
        logic [31:0] d;
        logic [2:0]  ra;
        logic [3:0]  eo;
        logic [31:0] er;
        bit          ei;
    } vec_t;

    typedef struct packed {
        logic [3:0]  eo;
        logic [31:0] er;
        bit          ei;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    soc_system_pio_start_ctrl #(
        .WIDTH(4), .RESET_VALUE(32'h5), .PULSE_LEN(3)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .in_done(in_done), .irq(irq)
    );

    soc_system_pio_start_ctrl #(
        .WIDTH(4), .RESET_VALUE(32'h5), .PULSE_LEN(8)
    ) u_dut8 (
        .clk(clk), .reset_n(rst8_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd8),
        .out_port(out8), .in_done(in_done), .irq(irq8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic add(input bit w, input logic [2:0] a, input logic [31:0] d,
                       input logic [2:0] ra, input logic [3:0] eo,
                       input logic [31:0] er, input bit ei);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.ra = ra; v.eo = eo; v.er = er; v.ei = ei;
        tbl.push_back(v);
    endtask

    // One bus cycle: optional write, then compare out_port, readdata@ra and irq
    task automatic cyc(input bit w, input logic [2:0] a, input logic [31:0] d,
                       input logic [2:0] ra, input logic [3:0] eo,
                       input logic [31:0] er, input bit ei, input string nm);
        exp_t e;
        e.eo = eo; e.er = er; e.ei = ei;
        sb.push_back(e);
        if (w) begin
            address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        end
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; address = ra; #1;
        e = sb.pop_front();
        chk({nm, "/out_port"}, 32'(out_port), 32'(e.eo));
        chk({nm, "/readdata"}, readdata, e.er);
        chk({nm, "/irq"}, 32'(irq), 32'(e.ei));
    endtask

    task automatic idle(input logic [2:0] ra, input logic [3:0] eo,
                        input logic [31:0] er, input bit ei, input string nm);
        cyc(1'b0, 3'd0, 32'h0, ra, eo, er, ei, nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; rst8_n = 1'b0; address = 3'd0; chipselect = 1'b0;
        write_n = 1'b1; writedata = 32'h0; in_done = 4'h0;

        // Level mode, atomic set/clear, undefined address, IRQMASK, MODE
        add(0, 0, 32'h0,  6, 4'h5, 32'h0, 0);
        add(0, 0, 32'h0,  0, 4'h5, 32'h5, 0);
        add(1, 0, 32'hA,  0, 4'hA, 32'hA, 0);
        add(0, 0, 32'h0,  6, 4'hA, 32'hA, 0);
        add(1, 0, 32'h3,  0, 4'h3, 32'h3, 0);
        add(1, 4, 32'h4,  0, 4'h7, 32'h7, 0);
        add(1, 5, 32'h1,  0, 4'h6, 32'h6, 0);
        add(1, 7, 32'hFF, 7, 4'h6, 32'h0, 0);
        add(0, 0, 32'h0,  0, 4'h6, 32'h6, 0);
        add(0, 0, 32'h0,  5, 4'h6, 32'h0, 0);
        add(1, 3, 32'h2,  3, 4'h6, 32'h2, 0);
        add(0, 0, 32'h0,  6, 4'h6, 32'hF, 0);
        add(1, 1, 32'h1,  1, 4'h6, 32'h1, 0);
        add(1, 0, 32'h0,  0, 4'h0, 32'h0, 0);
        add(0, 0, 32'h0,  4, 4'h0, 32'h0, 0);
        // Pulse of 3 cycles, re-set at cycle 1 does not extend it
        add(1, 4, 32'h1,  0, 4'h1, 32'h1, 0);
        add(1, 4, 32'h1,  0, 4'h1, 32'h1, 0);
        add(0, 0, 32'h0,  0, 4'h1, 32'h1, 0);
        add(0, 0, 32'h0,  0, 4'h0, 32'h0, 0);
        // OUTCLR at cycle 1 drops the pulse at once, no residue
        add(1, 4, 32'h1,  0, 4'h1, 32'h1, 0);
        add(1, 5, 32'h1,  0, 4'h0, 32'h0, 0);
        add(0, 0, 32'h0,  0, 4'h0, 32'h0, 0);
        add(0, 0, 32'h0,  0, 4'h0, 32'h0, 0);
        add(1, 1, 32'h0,  1, 4'h0, 32'h0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset/out_port", 32'(out_port), 32'h5);
        chk("reset/irq", 32'(irq), 32'h0);
        chk("reset/out8", 32'(out8), 32'h5);
        reset_n = 1'b1; rst8_n = 1'b1;

        foreach (tbl[i])
            cyc(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ra, tbl[i].eo, tbl[i].er,
                tbl[i].ei, $sformatf("vec%0d", i));

        // Done capture on channel 1 at the documented latency
        in_done = 4'h2;
        for (int k = 1; k <= LAT; k++) begin
            idle(2, 4'h0, (k == LAT) ? 32'h2 : 32'h0, (k == LAT),
                 $sformatf("done_lat%0d", k));
            if (k == 2) in_done = 4'h0;
        end
        idle(6, 4'h0, 32'hD, 1, "done_busy");
        cyc(1, 2, 32'h2, 2, 4'h0, 32'h0, 0, "done_w1c");
        for (int k = 0; k < 3; k++) idle(2, 4'h0, 32'h0, 0, "done_settle");

        // W1C coincident with a hardware edge: set wins
        in_done = 4'h1;
        for (int k = 1; k < LAT; k++) idle(2, 4'h0, 32'h0, 0, "simw1c_pre");
        cyc(1, 2, 32'h1, 2, 4'h0, 32'h1, 0, "simw1c_edge");
        in_done = 4'h0;
        idle(6, 4'h0, 32'hC, 0, "simw1c_busy");
        cyc(1, 2, 32'h1, 2, 4'h0, 32'h0, 0, "simw1c_clear");
        for (int k = 0; k < 3; k++) idle(2, 4'h0, 32'h0, 0, "simw1c_settle");

        // Start coincident with a done edge: busy stays set
        in_done = 4'h1;
        for (int k = 1; k < LAT; k++) idle(6, 4'h0, 32'hC, 0, "simstart_pre");
        cyc(1, 4, 32'h1, 6, 4'h1, 32'hD, 0, "simstart_busy");
        in_done = 4'h0;
        idle(2, 4'h1, 32'h1, 0, "simstart_edge");
        cyc(1, 2, 32'h1, 2, 4'h1, 32'h0, 0, "simstart_w1c");
        for (int k = 0; k < 3; k++) idle(2, 4'h1, 32'h0, 0, "simstart_settle");

        // Reset mid-pulse on the PULSE_LEN=8 instance
        cyc(1, 0, 32'h0, 0, 4'h0, 32'h0, 0, "rstp_data0");
        cyc(1, 1, 32'h2, 1, 4'h0, 32'h2, 0, "rstp_mode");
        cyc(1, 4, 32'h2, 0, 4'h2, 32'h2, 0, "rstp_start");
        chk("rstp_start/out8", 32'(out8), 32'h2);
        idle(0, 4'h2, 32'h2, 0, "rstp_cyc1");
        chk("rstp_cyc1/out8", 32'(out8), 32'h2);
        rst8_n = 1'b0; #1;
        chk("rstp_inreset/out8", 32'(out8), 32'h5);
        chk("rstp_inreset/irq8", 32'(irq8), 32'h0);
        chk("rstp_inreset/rd8", rd8, 32'h5);
        idle(0, 4'h2, 32'h2, 0, "rstp_hold");
        chk("rstp_hold/out8", 32'(out8), 32'h5);
        rst8_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            idle(0, 4'h0, 32'h0, 0, "rstp_after");
            chk($sformatf("rstp_after%0d/out8", k), 32'(out8), 32'h5);
        end
        idle(1, 4'h0, 32'h2, 0, "rstp_mode_rd");
        chk("rstp_mode_rd/rd8", rd8, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
